// File: rtl/usb_ep_fifo_mux_n.sv
// rtl/usb_ep_fifo_mux_n.sv - steers TX/RX FIFO ports to a per-transaction latched endpoint, counts bytes
// Optional macro USB_EP_FIFO_MUX_GUARD_EN: masks reads of empty / writes to full endpoints, sticky error bits.
module usb_ep_fifo_mux_n #(
  parameter int NUM_EP    = 4,
  parameter int EP_ADDR_W = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EP_ADDR_W-1:0]     currEndP,
  input  logic                     transStart,
  input  logic                     transDone,
  input  logic                     TxFifoREn,
  output logic [DATA_W-1:0]        TxFifoData,
  output logic                     TxFifoEmpty,
  output logic [NUM_EP-1:0]        TxFifoEPREn,
  input  logic [NUM_EP*DATA_W-1:0] TxFifoEPData,
  input  logic [NUM_EP-1:0]        TxFifoEPEmpty,
  input  logic                     RxFifoWEn,
  output logic                     RxFifoFull,
  output logic [NUM_EP-1:0]        RxFifoEPWEn,
  input  logic [NUM_EP-1:0]        RxFifoEPFull,
  output logic [EP_ADDR_W-1:0]     selEP,
  output logic                     transActive,
  output logic                     epInvalid,
  output logic [CNT_W-1:0]         txCount,
  output logic [CNT_W-1:0]         rxCount
`ifdef USB_EP_FIFO_MUX_GUARD_EN
  ,
  output logic [NUM_EP-1:0]        txUnderrun,
  output logic [NUM_EP-1:0]        rxOverrun
`endif
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [EP_ADDR_W:0] LP_NUM_EP  = (EP_ADDR_W+1)'(NUM_EP);
  localparam logic [CNT_W-1:0]   LP_CNT_MAX = '1;

  state_t               r_state;
  logic                 r_trans_active;
  logic [EP_ADDR_W-1:0] r_sel_ep;
  logic                 r_ep_invalid;
  logic [CNT_W-1:0]     r_tx_count;
  logic [CNT_W-1:0]     r_rx_count;

  logic [NUM_EP-1:0]    w_onehot;
  logic [DATA_W-1:0]    w_ep_data;
  logic                 w_ep_empty;
  logic                 w_ep_full;
  logic                 w_open;
  logic                 w_tx_fwd;
  logic                 w_rx_fwd;

  // Loop-based decode so an out-of-range selEP never indexes past the packed buses.
  always_comb begin
    w_onehot   = '0;
    w_ep_data  = '0;
    w_ep_empty = 1'b1;
    w_ep_full  = 1'b1;
    for (int i = 0; i < NUM_EP; i++) begin
      if (r_sel_ep == EP_ADDR_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_ep_data   = TxFifoEPData[i*DATA_W +: DATA_W];
        w_ep_empty  = TxFifoEPEmpty[i];
        w_ep_full   = RxFifoEPFull[i];
      end
    end
  end

  assign w_open = r_trans_active && !r_ep_invalid;

`ifdef USB_EP_FIFO_MUX_GUARD_EN
  assign w_tx_fwd = w_open && TxFifoREn && !w_ep_empty;
  assign w_rx_fwd = w_open && RxFifoWEn && !w_ep_full;
`else
  assign w_tx_fwd = w_open && TxFifoREn;
  assign w_rx_fwd = w_open && RxFifoWEn;
`endif

  assign TxFifoEPREn = w_tx_fwd ? w_onehot : '0;
  assign RxFifoEPWEn = w_rx_fwd ? w_onehot : '0;
  assign TxFifoEmpty = w_open ? w_ep_empty : 1'b1;
  assign RxFifoFull  = w_open ? w_ep_full  : 1'b1;
  assign TxFifoData  = r_ep_invalid ? '0 : w_ep_data;

  assign selEP       = r_sel_ep;
  assign transActive = r_trans_active;
  assign epInvalid   = r_ep_invalid;
  assign txCount     = r_tx_count;
  assign rxCount     = r_rx_count;

  // transStart wins over both transDone and a same-cycle count increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_trans_active <= 1'b0;
      r_sel_ep       <= '0;
      r_ep_invalid   <= 1'b0;
      r_tx_count     <= '0;
      r_rx_count     <= '0;
    end else if (transStart) begin
      r_state        <= S_ACTIVE;
      r_trans_active <= 1'b1;
      r_sel_ep       <= currEndP;
      r_ep_invalid   <= ({1'b0, currEndP} >= LP_NUM_EP);
      r_tx_count     <= '0;
      r_rx_count     <= '0;
    end else begin
      if (w_tx_fwd && (r_tx_count != LP_CNT_MAX))
        r_tx_count <= r_tx_count + 1'b1;
      if (w_rx_fwd && (r_rx_count != LP_CNT_MAX))
        r_rx_count <= r_rx_count + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_trans_active <= 1'b0;
        end
        S_ACTIVE: begin
          if (transDone) begin
            r_state        <= S_IDLE;
            r_trans_active <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_trans_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef USB_EP_FIFO_MUX_GUARD_EN
  logic [NUM_EP-1:0] r_tx_underrun;
  logic [NUM_EP-1:0] r_rx_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_underrun <= '0;
      r_rx_overrun  <= '0;
    end else begin
      if (w_open && TxFifoREn && w_ep_empty)
        r_tx_underrun <= r_tx_underrun | w_onehot;
      if (w_open && RxFifoWEn && w_ep_full)
        r_rx_overrun  <= r_rx_overrun | w_onehot;
    end
  end

  assign txUnderrun = r_tx_underrun;
  assign rxOverrun  = r_rx_overrun;
`endif

endmodule

// File: doc/usb_ep_fifo_mux_n.md
Name: usb_ep_fifo_mux_n

Overview:
- Parametrised endpoint FIFO multiplexer for the USB slave controller.
- Steers one TX (IN) FIFO read port and one RX (OUT) FIFO write port to one of NUM_EP endpoint FIFOs.
- The endpoint is latched per transaction. It is held stable while the protocol engine is mid-packet, and requests to unimplemented endpoints are rejected safely.
- Also counts bytes per transaction.
- Sits between the slave protocol engine and the endpoint FIFO bank.

Parameters:
- NUM_EP, 4, number of implemented endpoints (1..16).
- EP_ADDR_W, 4, width of the endpoint address from the token decoder.
- DATA_W, 8, FIFO data width.
- CNT_W, 11, width of the per-transaction byte counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- currEndP  in  EP_ADDR_W  endpoint address from the token decoder.
- transStart  in  1  one-cycle pulse: latch currEndP and open a transaction.
- transDone  in  1  one-cycle pulse: close the transaction.
- TxFifoREn  in  1  read request from the protocol engine.
- TxFifoData  out  DATA_W  data of the selected TX FIFO.
- TxFifoEmpty  out  1  empty flag of the selected TX FIFO.
- TxFifoEPREn  out  NUM_EP  per-endpoint read enables.
- TxFifoEPData  in  NUM_EP*DATA_W  packed data; EP n occupies [n*DATA_W +: DATA_W].
- TxFifoEPEmpty  in  NUM_EP  per-endpoint empty flags.
- RxFifoWEn  in  1  write request from the protocol engine.
- RxFifoFull  out  1  full flag of the selected RX FIFO.
- RxFifoEPWEn  out  NUM_EP  per-endpoint write enables.
- RxFifoEPFull  in  NUM_EP  per-endpoint full flags.
- selEP  out  EP_ADDR_W  latched endpoint.
- transActive  out  1  a transaction is open.
- epInvalid  out  1  latched endpoint is >= NUM_EP.
- txCount  out  CNT_W  TX bytes forwarded in this transaction.
- rxCount  out  CNT_W  RX bytes forwarded in this transaction.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; selEP=0; epInvalid=0; txCount=0; rxCount=0; error flags=0.
- Reset outputs while rst is high: TxFifoEPREn=0, RxFifoEPWEn=0, TxFifoEmpty=1, RxFifoFull=1, TxFifoData=EP0 data.
- States:
  - IDLE: transStart -> ACTIVE.
  - ACTIVE: transDone without transStart -> IDLE.
  - ACTIVE: transStart, with or without transDone, -> restart. Re-latch selEP, clear counters, remain ACTIVE.
- Latch: on a clk edge with transStart=1, selEP<=currEndP, epInvalid<=(currEndP>=NUM_EP), txCount<=0, rxCount<=0.
- Selection latency: the new endpoint steers from the next cycle. currEndP changes at any other time are ignored.
- transActive=1 exactly in ACTIVE.
- Combinational steering, valid when ACTIVE and not epInvalid:
  - TxFifoEPREn[selEP]=TxFifoREn; all other bits 0.
  - RxFifoEPWEn[selEP]=RxFifoWEn; all other bits 0.
  - TxFifoData=EP selEP data.
  - TxFifoEmpty=TxFifoEPEmpty[selEP].
  - RxFifoFull=RxFifoEPFull[selEP].
- Gated case (IDLE, or epInvalid=1):
  - All per-EP enables are 0.
  - TxFifoEmpty=1 and RxFifoFull=1, so the engine NAKs.
  - TxFifoData=0 when epInvalid=1; EP selEP data when in IDLE.
- Counters:
  - txCount increments on each cycle a TX enable is forwarded to an endpoint.
  - rxCount increments on each cycle an RX enable is forwarded.
  - Both saturate at 2^CNT_W-1, with no wrap.
  - Both hold value in IDLE until the next transStart.
  - The counter clear on transStart takes priority over an increment in the same cycle.
- Simultaneous TxFifoREn and RxFifoWEn are both forwarded independently.
- Flags:
  - epInvalid holds until the next latch.
  - Out-of-range address example (NUM_EP=4, currEndP=4'hF): nothing is enabled and the counters stay 0.

Optional Feature:
- Macro: USB_EP_FIFO_MUX_GUARD_EN.
- Defined: a forwarded TX enable is additionally masked when TxFifoEPEmpty[selEP]=1, and a forwarded RX enable is masked when RxFifoEPFull[selEP]=1.
- Defined: masked requests do not count.
- Defined: masked requests set sticky bits in extra output ports txUnderrun[NUM_EP] and rxOverrun[NUM_EP], indexed by selEP.
- Defined: the sticky bits are cleared only by rst.
- Not defined: enables pass through unqualified by empty/full, and the txUnderrun/rxOverrun ports do not exist.

Test Plan:
- Reset then idle: pulse TxFifoREn=1 and RxFifoWEn=1 without transStart -> TxFifoEPREn=0, RxFifoEPWEn=0, TxFifoEmpty=1, RxFifoFull=1, counters 0.
- transStart with currEndP=2, then 5 cycles TxFifoREn=1 with EP2 data 8'hA5 -> only TxFifoEPREn[2] toggles, TxFifoData=8'hA5, txCount=5 after transDone and held in IDLE.
- Latch EP1; mid-transaction change currEndP to 3; drive RxFifoWEn for 3 cycles -> only RxFifoEPWEn[1] toggles, selEP=1, rxCount=3.
- transStart with currEndP=9 (NUM_EP=4) -> epInvalid=1, TxFifoEmpty=1, RxFifoFull=1, TxFifoData=0, all enables 0; next transStart with EP0 clears epInvalid.
- transDone and transStart in the same cycle with currEndP=3 and txCount=7 -> transActive stays 1, selEP=3, txCount=0 next cycle. With CNT_W=3, 9 forwarded reads -> txCount saturates at 7.
- Assert rst mid-transaction -> IDLE, all enables 0, counters 0 immediately. With GUARD_EN: read of an empty EP2 -> no TxFifoEPREn, txUnderrun[2]=1, txCount unchanged.
